// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter sequencer.
//   pc_state_e    - sequencer states (BOOT, FETCH, HALT)
//   redir_cause_e - redirect causes; encoding order is priority order
//   DEF_*_VECTOR  - default reset and trap entry addresses
//   cause_wins()  - true when a new redirect may replace a held one
package pc_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

    // Numerically larger means higher priority, so causes compare directly.
    typedef enum logic [2:0] {
        RC_NONE   = 3'd0,
        RC_BRANCH = 3'd1,
        RC_JUMP   = 3'd2,
        RC_MRET   = 3'd3,
        RC_TRAP   = 3'd4
    } redir_cause_e;

    // A new redirect replaces a held one when it is at least as urgent.
    function automatic logic cause_wins(redir_cause_e new_cause, redir_cause_e held_cause);
        return new_cause >= held_cause;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational redirect priority mux.
//   Priority: trap > mret > jump > branch. A selected jump or branch whose
//   target is not word aligned is turned into a trap and flagged.
// Ports:
//   epc_i           - saved exception PC (mret target)
//   branch_taken_i  - branch resolved taken, target branch_target_i
//   jump_i          - unconditional jump, target jump_target_i
//   trap_i, mret_i  - trap entry / trap return requests
//   cause_o         - winning redirect cause (RC_NONE when no redirect)
//   target_o        - address for the winning cause
//   misalign_o      - winning jump/branch was misaligned and became a trap
module next_pc_sel
    import pc_pkg::*;
#(
    parameter int unsigned    N           = 32,
    parameter logic [N-1:0]   TRAP_VECTOR = N'(DEF_TRAP_VECTOR)
) (
    input  logic [N-1:0]  epc_i,
    input  logic          branch_taken_i,
    input  logic [N-1:0]  branch_target_i,
    input  logic          jump_i,
    input  logic [N-1:0]  jump_target_i,
    input  logic          trap_i,
    input  logic          mret_i,
    output redir_cause_e  cause_o,
    output logic [N-1:0]  target_o,
    output logic          misalign_o
);

    // NOTE: every output gets a default before any branch so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        cause_o    = RC_NONE;
        target_o   = '0;
        misalign_o = 1'b0;
        if (trap_i) begin
            cause_o  = RC_TRAP;
            target_o = TRAP_VECTOR;
        end else if (mret_i) begin
            cause_o  = RC_MRET;
            target_o = epc_i;
        end else if (jump_i) begin
            if (jump_target_i[1:0] != 2'b00) begin
                cause_o    = RC_TRAP;
                target_o   = TRAP_VECTOR;
                misalign_o = 1'b1;
            end else begin
                cause_o  = RC_JUMP;
                target_o = jump_target_i;
            end
        end else if (branch_taken_i) begin
            if (branch_target_i[1:0] != 2'b00) begin
                cause_o    = RC_TRAP;
                target_o   = TRAP_VECTOR;
                misalign_o = 1'b1;
            end else begin
                cause_o  = RC_BRANCH;
                target_o = branch_target_i;
            end
        end
    end

endmodule

// File: rtl/pc_controller.sv
// pc_controller: fetch-side PC sequencer with instruction-memory handshake.
//   Owns the PC, EPC and a one-entry pending-redirect register. Redirects that
//   arrive while a request waits for grant are held so the fetch address stays
//   stable; they are applied when the grant arrives.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   stall_i                    - hold PC, suppress request
//   halt_i                     - request HALT (level)
//   branch_taken_i/_target_i   - taken branch and its target
//   jump_i/jump_target_i       - jump and its target
//   trap_i, mret_i             - trap entry / trap return
//   imem_req_o, imem_addr_o    - fetch request and address (= pc_o)
//   imem_gnt_i                 - memory accepts current request
//   pc_o, epc_o                - current PC, saved exception PC
//   misalign_o                 - one-cycle pulse: misaligned redirect trapped
module pc_controller
    import pc_pkg::*;
#(
    parameter int unsigned    N            = 32,
    parameter logic [N-1:0]   RESET_VECTOR = N'(DEF_RESET_VECTOR),
    parameter logic [N-1:0]   TRAP_VECTOR  = N'(DEF_TRAP_VECTOR)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_i,
    input  logic          halt_i,
    input  logic          branch_taken_i,
    input  logic [N-1:0]  branch_target_i,
    input  logic          jump_i,
    input  logic [N-1:0]  jump_target_i,
    input  logic          trap_i,
    input  logic          mret_i,
    output logic          imem_req_o,
    output logic [N-1:0]  imem_addr_o,
    input  logic          imem_gnt_i,
    output logic [N-1:0]  pc_o,
    output logic [N-1:0]  epc_o,
    output logic          misalign_o
);

    pc_state_e     state_q, state_d;
    logic [N-1:0]  pc_q, pc_d;
    logic [N-1:0]  epc_q, epc_d;
    logic          pend_valid_q, pend_valid_d;
    logic [N-1:0]  pend_target_q, pend_target_d;
    redir_cause_e  pend_cause_q, pend_cause_d;
    logic          misalign_q, misalign_d;

    redir_cause_e  sel_cause;
    logic [N-1:0]  sel_target;
    logic          sel_misalign;
    logic          fetch_req;
    logic          accept;
    logic          redirect;

    next_pc_sel #(
        .N           (N),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_sel (
        .epc_i           (epc_q),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .trap_i          (trap_i),
        .mret_i          (mret_i),
        .cause_o         (sel_cause),
        .target_o        (sel_target),
        .misalign_o      (sel_misalign)
    );

    assign fetch_req = (state_q == ST_FETCH) && !stall_i;
    assign accept    = fetch_req && imem_gnt_i;
    assign redirect  = (sel_cause != RC_NONE);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        epc_d         = epc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_cause_d  = pend_cause_q;
        misalign_d    = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                // A trap is never discarded in FETCH (applied or held), so
                // the EPC can be captured as soon as it wins selection.
                if (sel_cause == RC_TRAP) begin
                    epc_d      = pc_q;
                    misalign_d = sel_misalign;
                end

                if (accept) begin
                    // A same-cycle redirect supersedes any stale held one.
                    if (redirect)
                        pc_d = sel_target;
                    else if (pend_valid_q)
                        pc_d = pend_target_q;
                    else
                        pc_d = pc_q + N'(4);
                    pend_valid_d = 1'b0;
                end else if (fetch_req) begin
                    // Request outstanding: hold the address, park the redirect.
                    if (redirect && (!pend_valid_q || cause_wins(sel_cause, pend_cause_q))) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = sel_target;
                        pend_cause_d  = sel_cause;
                    end
                end else if (redirect) begin
                    // No request on the bus: apply at once, keeping whichever
                    // of the new and held redirects is more urgent.
                    if (pend_valid_q && !cause_wins(sel_cause, pend_cause_q))
                        pc_d = pend_target_q;
                    else
                        pc_d = sel_target;
                    pend_valid_d = 1'b0;
                end

                // A parked redirect counts as outstanding work.
                if (halt_i && (accept || (!fetch_req && !pend_valid_d)))
                    state_d = ST_HALT;
            end

            ST_HALT: begin
                pend_valid_d = 1'b0;
                if (trap_i) begin
                    epc_d   = pc_q;
                    pc_d    = TRAP_VECTOR;
                    state_d = ST_FETCH;
                end else if (!halt_i) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_cause_q  <= RC_NONE;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_cause_q  <= pend_cause_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req_o  = fetch_req;
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign epc_o       = epc_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pc_controller.sv
// tb_pc_controller: directed self-checking bench for pc_controller.
//   Each step pushes the registered results expected after the next clock edge
//   onto a scoreboard queue; the entry is popped and compared once the edge
//   has passed. Combinational request/address outputs are checked directly.
module tb_pc_controller;

    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall_i = 1'b0;
    logic          halt_i = 1'b0;
    logic          branch_taken_i = 1'b0;
    logic [N-1:0]  branch_target_i = '0;
    logic          jump_i = 1'b0;
    logic [N-1:0]  jump_target_i = '0;
    logic          trap_i = 1'b0;
    logic          mret_i = 1'b0;
    logic          imem_req_o;
    logic [N-1:0]  imem_addr_o;
    logic          imem_gnt_i = 1'b1;
    logic [N-1:0]  pc_o;
    logic [N-1:0]  epc_o;
    logic          misalign_o;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string        tag;
        logic [N-1:0] pc;
        logic [N-1:0] epc;
        logic         mis;
    } exp_t;

    exp_t sb[$];

    pc_controller #(.N(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .halt_i          (halt_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .trap_i          (trap_i),
        .mret_i          (mret_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .pc_o            (pc_o),
        .epc_o           (epc_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push expectation, let one edge pass, then pop and compare.
    task automatic step(input string tag, input logic [N-1:0] pc, input logic [N-1:0] epc,
                        input logic mis);
        exp_t e;
        sb.push_back('{tag: tag, pc: pc, epc: epc, mis: mis});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".pc"},  pc_o, e.pc);
        check({e.tag, ".epc"}, epc_o, e.epc);
        check({e.tag, ".mis"}, {31'b0, misalign_o}, {31'b0, e.mis});
    endtask

    task automatic check_req(input string tag, input logic exp_req);
        #1;
        check({tag, ".req"}, {31'b0, imem_req_o}, {31'b0, exp_req});
    endtask

    initial begin
        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst.pc",  pc_o, 32'h0);
        check("rst.epc", epc_o, 32'h0);
        check("rst.req", {31'b0, imem_req_o}, 32'h0);
        check("rst.mis", {31'b0, misalign_o}, 32'h0);
        reset = 1'b0;
        check_req("boot", 1'b0);
        check("boot.pc", pc_o, 32'h0);
        step("boot2fetch", 32'h0, 32'h0, 1'b0);
        check_req("fetch0", 1'b1);
        check("fetch0.addr", imem_addr_o, 32'h0);
        step("seq4",  32'h4, 32'h0, 1'b0);
        step("seq8",  32'h8, 32'h0, 1'b0);
        step("seq12", 32'hC, 32'h0, 1'b0);

        // Park a jump, then reset mid-operation: pending must be lost.
        imem_gnt_i = 1'b0; jump_i = 1'b1; jump_target_i = 32'h60;
        step("park60", 32'hC, 32'h0, 1'b0);
        jump_i = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst.pc", pc_o, 32'h0);
        check("midrst.req", {31'b0, imem_req_o}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; imem_gnt_i = 1'b1;
        step("rb.fetch", 32'h0, 32'h0, 1'b0);
        step("rb.seq4",  32'h4, 32'h0, 1'b0);
        step("rb.seq8",  32'h8, 32'h0, 1'b0);

        // Jump held across three wait cycles.
        imem_gnt_i = 1'b0; jump_i = 1'b1; jump_target_i = 32'h40;
        #1 check("wait1.addr", imem_addr_o, 32'h8);
        step("wait1", 32'h8, 32'h0, 1'b0);
        jump_i = 1'b0;
        #1 check("wait2.addr", imem_addr_o, 32'h8);
        step("wait2", 32'h8, 32'h0, 1'b0);
        #1 check("wait3.addr", imem_addr_o, 32'h8);
        step("wait3", 32'h8, 32'h0, 1'b0);
        imem_gnt_i = 1'b1;
        step("gnt_jump", 32'h40, 32'h0, 1'b0);

        // Pending jump overwritten by a trap, then mret back.
        jump_i = 1'b1; jump_target_i = 32'h8;
        step("jump8", 32'h8, 32'h0, 1'b0);
        imem_gnt_i = 1'b0; jump_target_i = 32'h40;
        step("park40", 32'h8, 32'h0, 1'b0);
        jump_i = 1'b0; trap_i = 1'b1;
        step("park_trap", 32'h8, 32'h8, 1'b0);
        trap_i = 1'b0; imem_gnt_i = 1'b1;
        step("gnt_trap", 32'h100, 32'h8, 1'b0);
        mret_i = 1'b1;
        step("mret", 32'h8, 32'h8, 1'b0);
        mret_i = 1'b0;

        // Misaligned branch becomes a trap.
        step("seqC",  32'hC,  32'h8, 1'b0);
        step("seq10", 32'h10, 32'h8, 1'b0);
        branch_taken_i = 1'b1; branch_target_i = 32'h22;
        step("misalign", 32'h100, 32'h10, 1'b1);
        branch_taken_i = 1'b0;
        step("mis_clear", 32'h104, 32'h10, 1'b0);

        // Jump beats branch.
        jump_i = 1'b1; jump_target_i = 32'h200;
        branch_taken_i = 1'b1; branch_target_i = 32'h80;
        step("jump_over_br", 32'h200, 32'h10, 1'b0);
        jump_i = 1'b0; branch_taken_i = 1'b0;

        // Stall: no request, PC holds, redirect applied directly.
        stall_i = 1'b1;
        check_req("stall1", 1'b0);
        step("stall1", 32'h200, 32'h10, 1'b0);
        branch_taken_i = 1'b1; branch_target_i = 32'h80;
        step("stall_br", 32'h80, 32'h10, 1'b0);
        stall_i = 1'b0; branch_taken_i = 1'b0;
        check_req("unstall", 1'b1);
        step("post_stall", 32'h84, 32'h10, 1'b0);

        // HALT: entry, ignored jump, trap exit.
        jump_i = 1'b1; jump_target_i = 32'h20;
        step("jump20", 32'h20, 32'h10, 1'b0);
        jump_i = 1'b0; halt_i = 1'b1; stall_i = 1'b1;
        step("halt_in", 32'h20, 32'h10, 1'b0);
        stall_i = 1'b0;
        check_req("halted", 1'b0);
        jump_i = 1'b1; jump_target_i = 32'h40;
        step("halt_jump", 32'h20, 32'h10, 1'b0);
        jump_i = 1'b0; trap_i = 1'b1; halt_i = 1'b0;
        step("halt_trap", 32'h100, 32'h20, 1'b0);
        trap_i = 1'b0;
        check_req("halt_trap_out", 1'b1);

        // HALT exit on deassert keeps PC.
        halt_i = 1'b1; stall_i = 1'b1;
        step("halt2_in", 32'h100, 32'h20, 1'b0);
        halt_i = 1'b0; stall_i = 1'b0;
        check_req("halt2", 1'b0);
        step("halt2_out", 32'h100, 32'h20, 1'b0);
        check_req("resume", 1'b1);
        step("resume", 32'h104, 32'h20, 1'b0);

        // Wrap modulo 2^N.
        jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
        step("jump_top", 32'hFFFF_FFFC, 32'h20, 1'b0);
        jump_i = 1'b0;
        step("wrap", 32'h0, 32'h20, 1'b0);

        // Trap beats mret.
        trap_i = 1'b1; mret_i = 1'b1;
        step("trap_over_mret", 32'h100, 32'h0, 1'b0);
        trap_i = 1'b0; mret_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
# pc_controller

Fetch-side sequencer for the single-cycle core's program counter. It owns the PC register and decides the next PC each cycle: reset vector, sequential +4, branch, jump, trap entry or trap return. It also runs the req/gnt handshake to instruction memory and holds redirects that arrive while a fetch is still outstanding. It sits between the decode/execute control signals and the instruction-memory port.

## Interface
- N, 32, PC/address width
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset
- TRAP_VECTOR, 32'h0000_0100, PC value on trap entry
---
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall_i  in  1  pipeline stall; PC holds and no request is issued
- halt_i  in  1  enter HALT (level, sampled in FETCH)
- branch_taken_i  in  1  conditional branch resolved taken
- branch_target_i  in  N  branch target
- jump_i  in  1  unconditional jump (JAL/JALR)
- jump_target_i  in  N  jump target
- trap_i  in  1  external or illegal-instruction trap
- mret_i  in  1  return from trap
- imem_req_o  out  1  fetch request
- imem_addr_o  out  N  fetch address (= pc_o)
- imem_gnt_i  in  1  memory accepts the current request
- pc_o  out  N  current PC
- epc_o  out  N  saved exception PC
- misalign_o  out  1  one-cycle pulse: a misaligned redirect was converted to a trap

## Operation
- States: BOOT, FETCH, HALT.
- BOOT: `imem_req_o=0`. Always moves to FETCH on the next cycle.
- FETCH:
  - `imem_req_o = !stall_i`.
  - The PC advances only on an accept (`req & gnt`) or on a redirect applied while `imem_req_o=0`.
- Next-PC priority: trap > mret > jump > branch > sequential (`pc_o + 4`, wraps modulo 2^N).
- Trap: `epc_o <= pc_o`, target TRAP_VECTOR.
- mret: target `epc_o`.
- Misaligned target (`target[1:0] != 0`) on jump or branch: treated as a trap, and `misalign_o` pulses.
- A redirect while `req=1` and `gnt=0` is latched in a pending register (`pend_valid`, `pend_target`). `imem_addr_o` stays stable until gnt. On gnt, `pc_o <= pend_target` and pending clears.
- A later redirect while pending overwrites the pending entry only if it has equal or higher priority. A trap always overwrites.
- Redirect in the same cycle as gnt: applied directly, and any stale pending entry is discarded.
- Redirect while `imem_req_o=0` (stall): applied immediately.
- HALT:
  - Entered from FETCH when `halt_i=1` and no request is outstanding (`req=0` or gnt this cycle).
  - `imem_req_o=0`, PC holds.
  - `trap_i` exits to FETCH with PC = TRAP_VECTOR.
  - Deasserting `halt_i` exits to FETCH with PC unchanged.
  - All other redirects are ignored.

## Timing
- Reset values: `pc_o = RESET_VECTOR`, `epc_o = 0`, `imem_req_o = 0`, `misalign_o = 0`, pending cleared, state BOOT.
- First request is at the second rising edge after reset release (BOOT → FETCH).
- `pc_o` and `epc_o` are registered; a redirect is visible on `pc_o` one cycle after acceptance. `imem_req_o` is combinational from state and `stall_i`.
- Zero-wait memory (gnt tied high) gives one new PC per cycle.
- Reset mid-operation clears state immediately; a pending redirect is lost.

## Structure
- Package `pc_pkg`:
  - state enum `pc_state_e`
  - redirect-cause enum (NONE, BRANCH, JUMP, MRET, TRAP) with priority ordering
  - default RESET_VECTOR and TRAP_VECTOR constants
- Sub-module `next_pc_sel`: combinational priority mux and misalign check, producing cause and target. The FSM, PC/EPC registers and pending register stay in `pc_controller`.

## Test plan
- Reset held 3 cycles, then released, gnt=1 → `pc_o=0`, `req=0` in BOOT; then PC sequence 0, 4, 8, 12 on successive cycles.
- gnt=0 for 3 cycles at PC=8 with `jump_i`, target 0x40, on the first cycle → `imem_addr_o` stays 8; after gnt, `pc_o=0x40`.
- Jump 0x40 pending, then `trap_i` before gnt → after gnt, `pc_o=0x100` and `epc_o=8`. Then `mret_i` with gnt → `pc_o=8`.
- `branch_taken_i` with target 0x22 at PC=0x10 → `misalign_o` pulses, `pc_o=0x100`, `epc_o=0x10`.
- `stall_i=1` for 2 cycles → `req=0`, PC constant; a branch to 0x80 during the stall → `pc_o=0x80` next cycle.
- `halt_i=1` at PC=0x20 → HALT, `req=0`; jump ignored; `trap_i` → FETCH with `pc_o=0x100`.
- With N=32, PC=0xFFFF_FFFC and gnt → `pc_o=0` (wrap).
